// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and helpers for the frequency meter
package freq_meter_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} fm_state_t;

  // Expected edges per gate window; integer truncation is intentional.
  function automatic int exp_count(input int base, input int salida, input int gate);
    return (salida * gate) / base;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// rtl/freq_meter_sync_edge_detect.sv - two-flop synchronizer with rising-edge pulse
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  // meta_q/s1_q form the synchronizer; s2_q holds the previous synchronized value
  logic meta_q, meta_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Shift the asynchronous input down the synchronizer chain
  always_comb begin
    meta_d = async_in;
    s1_d   = meta_q;
    s2_d   = s1_q;
  end

  // Synchronizer registers, cleared to 0 by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign edge_pulse = s1_q & ~s2_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts sig_in rising edges per gate window and flags tolerance
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int FREC_BASE     = 100,
  parameter int FREC_ESPERADA = 10,
  parameter int GATE_CYCLES   = 1000,
  parameter int TOL           = 1,
  parameter int CNT_W         = $clog2(GATE_CYCLES + 1)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             no_signal
);

  localparam int EXP_COUNT = exp_count(FREC_BASE, FREC_ESPERADA, GATE_CYCLES);
  localparam int GATE_W    = $clog2(GATE_CYCLES);
  localparam int CW1       = CNT_W + 1;
  localparam int CMP_MAX   = (1 << CW1) - 1;
  // Tolerance band bounds, clamped so they stay representable in CNT_W+1 bits
  localparam int LO_I      = (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
  localparam int HI_I      = (EXP_COUNT + TOL > CMP_MAX) ? CMP_MAX : EXP_COUNT + TOL;
  localparam int LO_C      = (LO_I > CMP_MAX) ? CMP_MAX : LO_I;

  localparam logic [CW1-1:0]    CMP_LO    = CW1'(LO_C);
  localparam logic [CW1-1:0]    CMP_HI    = CW1'(HI_I);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic              edge_pulse;
  fm_state_t         state_q, state_d;
  logic              settle_q, settle_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  acc_sum;
  logic [CW1-1:0]    cmp_val;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              count_valid_q, count_valid_d;
  logic              in_range_q, in_range_d;
  logic              no_signal_q, no_signal_d;

  sync_edge_detect u_sync (
    .clk        (clk_in),
    .rst_n      (reset),
    .async_in   (sig_in),
    .edge_pulse (edge_pulse)
  );

  // Window count including this cycle's edge, saturating at the counter maximum
  always_comb begin
    acc_sum = (acc_q == CNT_MAX) ? acc_q : acc_q + CNT_W'(edge_pulse);
    cmp_val = {1'b0, acc_sum};
  end

  // FSM next state, gate countdown, accumulation and result latching
  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    gate_d        = gate_q;
    acc_d         = acc_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    in_range_d    = in_range_q;
    no_signal_d   = no_signal_q;
    if (!en) begin
      // Abandon any window in progress; results keep their last values
      state_d  = IDLE;
      settle_d = 1'b0;
      gate_d   = GATE_LAST;
      acc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          settle_d = 1'b0;
          gate_d   = GATE_LAST;
          acc_d    = '0;
          state_d  = SETTLE;
        end
        SETTLE: begin
          // Two cycles of discarded pulses let stale synchronizer contents drain
          gate_d   = GATE_LAST;
          acc_d    = '0;
          settle_d = 1'b1;
          if (settle_q) state_d = MEASURE;
        end
        MEASURE: begin
          if (gate_q == '0) begin
            // Terminal cycle: publish and start the next window without a gap
            edge_count_d  = acc_sum;
            count_valid_d = 1'b1;
            in_range_d    = (cmp_val >= CMP_LO) && (cmp_val <= CMP_HI);
            no_signal_d   = (acc_sum == '0);
            gate_d        = GATE_LAST;
            acc_d         = '0;
          end else begin
            gate_d = gate_q - GATE_W'(1);
            acc_d  = acc_sum;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      settle_q      <= 1'b0;
      gate_q        <= GATE_LAST;
      acc_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      no_signal_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      gate_q        <= gate_d;
      acc_q         <= acc_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      no_signal_q   <= no_signal_d;
    end
  end

  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign no_signal   = no_signal_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter
`timescale 1ns/1ps
module tb_freq_meter;

  // dut_a: defaults (expected 10*1000/100 = 100 edges, TOL 1, 10-bit count)
  // dut_b: 25 MHz over 40 cycles (expected 25*40/100 = 10, TOL 2, 4-bit count saturating at 15)
  localparam int GA = 1000;
  localparam int GB = 40;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       en     = 1'b0;
  logic       sig_in = 1'b0;
  logic [9:0] edge_count_a;
  logic [3:0] edge_count_b;
  logic       count_valid_a, count_valid_b;
  logic       in_range_a, in_range_b;
  logic       no_signal_a, no_signal_b;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int half   = 5;
  bit mon_on = 1'b0;

  always #5 clk_in = ~clk_in;

  freq_meter dut_a (
    .clk_in      (clk_in),
    .reset       (reset),
    .en          (en),
    .sig_in      (sig_in),
    .edge_count  (edge_count_a),
    .count_valid (count_valid_a),
    .in_range    (in_range_a),
    .no_signal   (no_signal_a)
  );

  freq_meter #(
    .FREC_BASE     (100),
    .FREC_ESPERADA (25),
    .GATE_CYCLES   (GB),
    .TOL           (2),
    .CNT_W         (4)
  ) dut_b (
    .clk_in      (clk_in),
    .reset       (reset),
    .en          (en),
    .sig_in      (sig_in),
    .edge_count  (edge_count_b),
    .count_valid (count_valid_b),
    .in_range    (in_range_b),
    .no_signal   (no_signal_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Reference model: per-edge history of the sampled input, consecutive-enable run length,
  // and the window rule (first counted edge is the 4th enabled edge, windows of G edges).
  int ecount = 0;
  bit sig_hist[$];
  int run = 0;
  int g_of[2]   = '{GA, GB};
  int exp_of[2] = '{100, 10};
  int tol_of[2] = '{1, 2};
  int max_of[2] = '{1023, 15};
  int wsum[2]    = '{0, 0};
  int exp_cnt[2] = '{0, 0};
  bit exp_val[2] = '{1'b0, 1'b0};
  bit exp_inr[2] = '{1'b0, 1'b0};
  bit exp_nos[2] = '{1'b0, 1'b0};
  bit pulse_m;
  int cnt_m, lo_m;

  always @(posedge clk_in) begin
    ecount++;
    sig_hist.push_back(reset ? sig_in : 1'b0);
    pulse_m = (sig_hist.size() >= 4) ? (sig_hist[$-2] & ~sig_hist[$-3]) : 1'b0;
    if (!reset) begin
      run = 0;
      for (int d = 0; d < 2; d++) begin
        wsum[d] = 0; exp_cnt[d] = 0; exp_val[d] = 0; exp_inr[d] = 0; exp_nos[d] = 0;
      end
    end else if (!en) begin
      run = 0;
      for (int d = 0; d < 2; d++) exp_val[d] = 0;
    end else begin
      run++;
      for (int d = 0; d < 2; d++) begin
        exp_val[d] = 0;
        if (run >= 4) begin
          wsum[d] += int'(pulse_m);
          if ((run - 4) % g_of[d] == g_of[d] - 1) begin
            cnt_m      = (wsum[d] > max_of[d]) ? max_of[d] : wsum[d];
            lo_m       = (exp_of[d] > tol_of[d]) ? exp_of[d] - tol_of[d] : 0;
            exp_cnt[d] = cnt_m;
            exp_val[d] = 1;
            exp_inr[d] = (cnt_m >= lo_m) && (cnt_m <= exp_of[d] + tol_of[d]);
            exp_nos[d] = (cnt_m == 0);
            wsum[d]    = 0;
          end
        end else begin
          wsum[d] = 0;
        end
      end
    end
  end

  // Compare all outputs against the model away from the active edge
  always @(negedge clk_in) begin
    if (mon_on) begin
      check("a_valid", 32'(count_valid_a), reset ? 32'(exp_val[0]) : 0);
      check("a_count", 32'(edge_count_a),  reset ? exp_cnt[0] : 0);
      check("a_range", 32'(in_range_a),    reset ? 32'(exp_inr[0]) : 0);
      check("a_nosig", 32'(no_signal_a),   reset ? 32'(exp_nos[0]) : 0);
      check("b_valid", 32'(count_valid_b), reset ? 32'(exp_val[1]) : 0);
      check("b_count", 32'(edge_count_b),  reset ? exp_cnt[1] : 0);
      check("b_range", 32'(in_range_b),    reset ? 32'(exp_inr[1]) : 0);
      check("b_nosig", 32'(no_signal_b),   reset ? 32'(exp_nos[1]) : 0);
    end
  end

  // sig_in generator: 0 = held low, 1 = divider toggling every 'half' cycles, 2 = random bits
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk_in);
      #1;
      case (mode)
        1: begin
          cnt++;
          if (cnt >= half) begin
            cnt    = 0;
            sig_in = ~sig_in;
          end
        end
        2: sig_in = 1'($urandom_range(0, 1));
        default: begin
          sig_in = 1'b0;
          cnt    = 0;
        end
      endcase
    end
  end

  // Raise en now and check the first result lands GATE_CYCLES+3 edges later
  task automatic en_rise_latency(input string tag);
    int rise;
    int k;
    en   = 1'b1;
    rise = ecount;
    k    = 0;
    while (k < GA + 100) begin
      @(negedge clk_in);
      k++;
      if (count_valid_a) break;
    end
    check(tag, ecount - rise, GA + 3);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int k;
    cyc(3);
    mon_on = 1'b1;
    check("rst_count", 32'(edge_count_a), 0);
    check("rst_valid", 32'(count_valid_a), 0);
    check("rst_range", 32'(in_range_a), 0);
    check("rst_nosig", 32'(no_signal_a), 0);
    reset = 1'b1;
    cyc(2);

    // 10 MHz divider output, then 50 MHz, then 1 MHz, then no signal
    mode = 1; half = 5;
    cyc(20);
    en = 1'b1;
    cyc(3 * GA + 10);
    half = 1;
    cyc(2 * GA + 10);
    half = 50;
    cyc(2 * GA + 10);
    mode = 0;
    cyc(2 * GA + 10);

    // Abort a window at its midpoint for 20 cycles
    mode = 1; half = 5;
    cyc(2 * GA + 10);
    k = 0;
    while (!count_valid_a && k < GA + 100) begin
      @(negedge clk_in);
      k++;
    end
    cyc(500);
    en = 1'b0;
    cyc(20);
    en_rise_latency("en_restart_latency");

    // Asynchronous reset between clock edges, mid-window
    cyc(400);
    @(posedge clk_in);
    #3;
    reset = 1'b0;
    en    = 1'b0;
    #1;
    check("arst_count", 32'(edge_count_a), 0);
    check("arst_range", 32'(in_range_a), 0);
    check("arst_nosig", 32'(no_signal_a), 0);
    check("arst_count_b", 32'(edge_count_b), 0);
    cyc(3);
    reset = 1'b1;
    cyc(2);
    en_rise_latency("reset_restart_latency");

    // Randomized patterns with occasional enable drops
    for (int i = 0; i < 10; i++) begin
      mode = $urandom_range(0, 2);
      half = $urandom_range(1, 12);
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0;
        cyc($urandom_range(1, 6));
      end
      en = 1'b1;
      cyc($urandom_range(300, 1500));
    end

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
